// File: rtl/tx_inband_pkg.sv
// Shared definitions for the TX inband packet path: header field positions,
// limits, and the demux FSM state / drop-reason encodings.
package tx_inband_pkg;

   localparam int CHAN_MSB = 20;
   localparam int CHAN_LSB = 16;
   localparam int LEN_MSB  = 8;
   localparam int LEN_LSB  = 0;

   localparam logic [CHAN_MSB-CHAN_LSB:0] CTRL_CHAN = 5'h1f;
   localparam int MAX_PAYLOAD = 504;

   typedef enum logic [1:0] {
      IDLE,
      FWD,
      DROP
   } demux_state_e;

   typedef enum logic [1:0] {
      RSN_OK,
      RSN_BAD_CHAN,
      RSN_BAD_LEN,
      RSN_NO_SPACE
   } drop_reason_e;

endpackage

// File: rtl/tx_chan_demux_hdr_check.sv
// Combinational decode of an inband header word: maps the channel field to a
// buffer index and decides whether the packet may be forwarded, and why not.
module tx_hdr_check
   import tx_inband_pkg::*;
#(
   parameter int NUM_CHAN = 2,
   parameter int CIDX_W   = $clog2(NUM_CHAN + 1)
) (
   input  logic [CHAN_MSB-CHAN_LSB:0] chan_i,
   input  logic [LEN_MSB-LEN_LSB:0]   len_i,
   input  logic [NUM_CHAN:0]          have_space_i,
   output logic [CIDX_W-1:0]          chan_idx_o,
   output logic                       accept_o,
   output drop_reason_e               reason_o
);

   logic chan_ok;

   always_comb begin
      chan_ok    = 1'b1;
      chan_idx_o = '0;
      if (chan_i == CTRL_CHAN) begin
         chan_idx_o = CIDX_W'(NUM_CHAN);
      end else if (int'(chan_i) < NUM_CHAN) begin
         chan_idx_o = CIDX_W'(chan_i);
      end else begin
         chan_ok = 1'b0;
      end

      // Space is only meaningful once the channel is known to exist.
      if (!chan_ok) begin
         reason_o = RSN_BAD_CHAN;
      end else if (int'(len_i) > MAX_PAYLOAD) begin
         reason_o = RSN_BAD_LEN;
      end else if (!have_space_i[chan_idx_o]) begin
         reason_o = RSN_NO_SPACE;
      end else begin
         reason_o = RSN_OK;
      end
      accept_o = (reason_o == RSN_OK);
   end

endmodule

// File: rtl/tx_chan_demux.sv
// Routes fixed-length inband packets from the packer word stream to per-channel
// buffers. Optional saturating statistics counters under TX_DEMUX_STATS_EN.
module tx_chan_demux
   import tx_inband_pkg::*;
#(
   parameter int NUM_CHAN  = 2,
   parameter int PKT_WORDS = 128
) (
   input  logic                txclk,
   input  logic                reset,
   input  logic [31:0]         usbdata_final,
   input  logic                WR_final,
   input  logic [NUM_CHAN:0]   have_space,
   output logic [31:0]         ram_data,
   output logic [NUM_CHAN:0]   WR_channel,
   output logic [NUM_CHAN:0]   WR_done_channel,
   output logic                pkt_dropped
`ifdef TX_DEMUX_STATS_EN
   ,
   output logic [15:0]         drop_count,
   output logic [15:0]         pkt_count
`endif
);

   localparam int CIDX_W = $clog2(NUM_CHAN + 1);
   localparam int CNT_W  = $clog2(PKT_WORDS);
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(PKT_WORDS - 1);

   demux_state_e         state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [CIDX_W-1:0]    chan_q, chan_d;
   logic [31:0]          data_q, data_d;
   logic [NUM_CHAN:0]    wr_q, wr_d;
   logic [NUM_CHAN:0]    done_q, done_d;
   logic                 drop_q, drop_d;

   logic [CIDX_W-1:0]    hdr_chan;
   logic                 hdr_accept;
   drop_reason_e         hdr_reason;
   logic                 hdr_go;

   tx_hdr_check #(
      .NUM_CHAN (NUM_CHAN),
      .CIDX_W   (CIDX_W)
   ) u_hdr_check (
      .chan_i       (usbdata_final[CHAN_MSB:CHAN_LSB]),
      .len_i        (usbdata_final[LEN_MSB:LEN_LSB]),
      .have_space_i (have_space),
      .chan_idx_o   (hdr_chan),
      .accept_o     (hdr_accept),
      .reason_o     (hdr_reason)
   );

   // Accept flag and reason are two views of one decode; both must agree.
   assign hdr_go = hdr_accept & (hdr_reason == RSN_OK);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      chan_d  = chan_q;
      data_d  = data_q;
      wr_d    = '0;
      done_d  = '0;
      drop_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (WR_final) begin
               chan_d = hdr_chan;
               cnt_d  = CNT_W'(1);
               if (hdr_go) begin
                  state_d        = FWD;
                  data_d         = usbdata_final;
                  wr_d[hdr_chan] = 1'b1;
               end else begin
                  state_d = DROP;
                  drop_d  = 1'b1;
               end
            end
         end
         FWD: begin
            if (WR_final) begin
               data_d       = usbdata_final;
               wr_d[chan_q] = 1'b1;
               if (cnt_q == LAST_WORD) begin
                  done_d[chan_q] = 1'b1;
                  cnt_d          = '0;
                  state_d        = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         DROP: begin
            if (WR_final) begin
               if (cnt_q == LAST_WORD) begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge txclk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         chan_q  <= '0;
         data_q  <= '0;
         wr_q    <= '0;
         done_q  <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         chan_q  <= chan_d;
         data_q  <= data_d;
         wr_q    <= wr_d;
         done_q  <= done_d;
         drop_q  <= drop_d;
      end
   end

   assign ram_data        = data_q;
   assign WR_channel      = wr_q;
   assign WR_done_channel = done_q;
   assign pkt_dropped     = drop_q;

`ifdef TX_DEMUX_STATS_EN
   logic [15:0] drop_cnt_q, pkt_cnt_q;

   always_ff @(posedge txclk) begin
      if (reset) begin
         drop_cnt_q <= '0;
         pkt_cnt_q  <= '0;
      end else begin
         if (drop_d && (drop_cnt_q != 16'hffff)) drop_cnt_q <= drop_cnt_q + 16'd1;
         if ((|done_d) && (pkt_cnt_q != 16'hffff)) pkt_cnt_q <= pkt_cnt_q + 16'd1;
      end
   end

   assign drop_count = drop_cnt_q;
   assign pkt_count  = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_tx_chan_demux.sv
// Self-checking bench for tx_chan_demux: packet-level reference model decides
// accept/drop per header; every strobed word is checked against it.
module tb_tx_chan_demux;

   localparam int NC = 2;
   localparam int PW = 128;

   logic          txclk = 1'b0;
   logic          reset;
   logic [31:0]   usbdata_final;
   logic          WR_final;
   logic [NC:0]   have_space;
   logic [31:0]   ram_data;
   logic [NC:0]   WR_channel;
   logic [NC:0]   WR_done_channel;
   logic          pkt_dropped;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_ram;
   logic [31:0] sent     [PW];
   logic [NC:0] obs_wr   [PW];
   logic [NC:0] obs_done [PW];
   logic        obs_drop [PW];
   logic [31:0] obs_data [PW];
   int          gap_busy;
   int          gap_hold_bad;

   tx_chan_demux #(.NUM_CHAN(NC), .PKT_WORDS(PW)) dut (
      .txclk           (txclk),
      .reset           (reset),
      .usbdata_final   (usbdata_final),
      .WR_final        (WR_final),
      .have_space      (have_space),
      .ram_data        (ram_data),
      .WR_channel      (WR_channel),
      .WR_done_channel (WR_done_channel),
      .pkt_dropped     (pkt_dropped)
   );

   always #5 txclk = ~txclk;

   // Packet-level rule: which buffer (one-hot) receives this packet, or 0 if dropped.
   function automatic logic [NC:0] exp_mask(input logic [31:0] hdr, input logic [NC:0] sp);
      int ch, len, idx;
      logic [NC:0] m;
      ch  = int'(hdr[20:16]);
      len = int'(hdr[8:0]);
      m   = '0;
      if (ch == 31) idx = NC;
      else if (ch < NC) idx = ch;
      else return m;
      if (len > 504 || !sp[idx]) return m;
      m[idx] = 1'b1;
      return m;
   endfunction

   task automatic step();
      @(posedge txclk);
      #1;
   endtask

   // Drives n words of one packet (word 0 = hdr) with 'gap' idle cycles between
   // words, and records what the DUT shows one cycle after each strobe.
   task automatic send_packet(input logic [31:0] hdr, input int n, input int gap,
                              input logic [NC:0] sp_hdr, input logic [NC:0] sp_late,
                              input int chg_at);
      gap_busy     = 0;
      gap_hold_bad = 0;
      for (int k = 0; k < n; k++) begin
         if (k > 0) begin
            for (int g = 0; g < gap; g++) begin
               WR_final      = 1'b0;
               usbdata_final = $urandom;
               step();
               if (WR_channel != 0 || WR_done_channel != 0 || pkt_dropped) gap_busy++;
               if (ram_data !== obs_data[k-1]) gap_hold_bad++;
            end
         end
         sent[k]       = (k == 0) ? hdr : $urandom;
         have_space    = (k >= chg_at) ? sp_late : sp_hdr;
         WR_final      = 1'b1;
         usbdata_final = sent[k];
         step();
         obs_wr[k]   = WR_channel;
         obs_done[k] = WR_done_channel;
         obs_drop[k] = pkt_dropped;
         obs_data[k] = ram_data;
      end
      WR_final = 1'b0;
   endtask

   task automatic test_reset();
      reset         = 1'b1;
      WR_final      = 1'b0;
      usbdata_final = 32'h0;
      have_space    = '1;
      repeat (3) step();
      n_checks += 4;
      if (ram_data !== 32'h0) begin n_fail++; $display("FAIL reset ram_data: got %h want 0", ram_data); end
      if (WR_channel !== '0) begin n_fail++; $display("FAIL reset WR_channel: got %b want 0", WR_channel); end
      if (WR_done_channel !== '0) begin n_fail++; $display("FAIL reset WR_done_channel: got %b want 0", WR_done_channel); end
      if (pkt_dropped !== 1'b0) begin n_fail++; $display("FAIL reset pkt_dropped: got %b want 0", pkt_dropped); end
      reset   = 1'b0;
      exp_ram = 32'h0;
      $display("reset: outputs checked");
   endtask

   task automatic test_back_to_back(input logic [31:0] hdr, input logic [NC:0] sp, input string name);
      logic [NC:0] mask;
      logic [31:0] ed;
      send_packet(hdr, PW, 0, sp, sp, PW);
      mask = exp_mask(hdr, sp);
      for (int k = 0; k < PW; k++) begin
         ed = (mask != 0) ? sent[k] : exp_ram;
         n_checks++;
         if (obs_wr[k] !== mask || obs_done[k] !== ((k == PW-1) ? mask : '0) ||
             obs_drop[k] !== (k == 0 && mask == 0) || obs_data[k] !== ed) begin
            n_fail++;
            $display("FAIL %s word %0d: got wr=%b done=%b drop=%b data=%h, want wr=%b done=%b drop=%b data=%h",
                     name, k, obs_wr[k], obs_done[k], obs_drop[k], obs_data[k],
                     mask, (k == PW-1) ? mask : '0, (k == 0 && mask == 0), ed);
         end
      end
      if (mask != 0) exp_ram = sent[PW-1];
      $display("%s: hdr=%h space=%b -> expected mask=%b", name, hdr, sp, mask);
   endtask

   task automatic test_sparse_ctrl();
      logic [NC:0] mask;
      logic [31:0] ed;
      send_packet(32'h001F_0010, PW, 2, 3'b111, 3'b111, PW);
      mask = exp_mask(32'h001F_0010, 3'b111);
      for (int k = 0; k < PW; k++) begin
         ed = (mask != 0) ? sent[k] : exp_ram;
         n_checks++;
         if (obs_wr[k] !== mask || obs_done[k] !== ((k == PW-1) ? mask : '0) ||
             obs_drop[k] !== (k == 0 && mask == 0) || obs_data[k] !== ed) begin
            n_fail++;
            $display("FAIL sparse word %0d: got wr=%b done=%b drop=%b data=%h, want wr=%b data=%h",
                     k, obs_wr[k], obs_done[k], obs_drop[k], obs_data[k], mask, ed);
         end
      end
      n_checks += 2;
      if (gap_busy !== 0) begin n_fail++; $display("FAIL sparse idle strobes: got %0d busy cycles want 0", gap_busy); end
      if (gap_hold_bad !== 0) begin n_fail++; $display("FAIL sparse ram_data hold: got %0d changes want 0", gap_hold_bad); end
      if (mask != 0) exp_ram = sent[PW-1];
      $display("sparse ctrl: hdr=001f0010 every 3rd cycle -> expected mask=%b", mask);
   endtask

   task automatic test_space_change();
      logic [NC:0] mask;
      logic [31:0] ed;
      test_back_to_back(32'h0001_0010, 3'b101, "no_space");
      send_packet(32'h0001_0010, PW, 0, 3'b111, 3'b101, 10);
      mask = exp_mask(32'h0001_0010, 3'b111);
      for (int k = 0; k < PW; k++) begin
         ed = (mask != 0) ? sent[k] : exp_ram;
         n_checks++;
         if (obs_wr[k] !== mask || obs_done[k] !== ((k == PW-1) ? mask : '0) ||
             obs_drop[k] !== 1'b0 || obs_data[k] !== ed) begin
            n_fail++;
            $display("FAIL space_mid word %0d: got wr=%b done=%b drop=%b data=%h, want wr=%b data=%h",
                     k, obs_wr[k], obs_done[k], obs_drop[k], obs_data[k], mask, ed);
         end
      end
      if (mask != 0) exp_ram = sent[PW-1];
      $display("space_mid: ch1 have_space dropped at word 10 -> expected mask=%b", mask);
   endtask

   task automatic test_reset_mid_packet();
      logic [NC:0] mask;
      send_packet(32'h0000_0040, 60, 0, 3'b111, 3'b111, PW);
      mask = exp_mask(32'h0000_0040, 3'b111);
      for (int k = 0; k < 60; k++) begin
         n_checks++;
         if (obs_wr[k] !== mask || obs_done[k] !== '0 || obs_drop[k] !== 1'b0 || obs_data[k] !== sent[k]) begin
            n_fail++;
            $display("FAIL partial word %0d: got wr=%b done=%b drop=%b data=%h, want wr=%b done=0 drop=0 data=%h",
                     k, obs_wr[k], obs_done[k], obs_drop[k], obs_data[k], mask, sent[k]);
         end
      end
      reset         = 1'b1;
      WR_final      = 1'b1;
      usbdata_final = $urandom;
      step();
      n_checks += 4;
      if (ram_data !== 32'h0) begin n_fail++; $display("FAIL midreset ram_data: got %h want 0", ram_data); end
      if (WR_channel !== '0) begin n_fail++; $display("FAIL midreset WR_channel: got %b want 0", WR_channel); end
      if (WR_done_channel !== '0) begin n_fail++; $display("FAIL midreset WR_done_channel: got %b want 0", WR_done_channel); end
      if (pkt_dropped !== 1'b0) begin n_fail++; $display("FAIL midreset pkt_dropped: got %b want 0", pkt_dropped); end
      reset    = 1'b0;
      WR_final = 1'b0;
      exp_ram  = 32'h0;
      $display("reset at word 60: outputs cleared");
      test_back_to_back(32'h0001_0020, 3'b111, "after_reset");
   endtask

   task automatic test_random();
      logic [31:0] hdr;
      logic [NC:0] sp, mask;
      logic [31:0] ed;
      int gap, pick;
      for (int p = 0; p < 8; p++) begin
         hdr  = $urandom;
         pick = $urandom_range(0, 3);
         hdr[20:16] = (pick == 0) ? 5'd0 : (pick == 1) ? 5'd1 : (pick == 2) ? 5'h1f : 5'($urandom_range(2, 30));
         hdr[8:0]   = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(505, 511)) : 9'($urandom_range(0, 504));
         sp   = 3'($urandom_range(0, 7));
         gap  = $urandom_range(0, 1);
         send_packet(hdr, PW, gap, sp, 3'($urandom_range(0, 7)), $urandom_range(1, PW-1));
         mask = exp_mask(hdr, sp);
         for (int k = 0; k < PW; k++) begin
            ed = (mask != 0) ? sent[k] : exp_ram;
            n_checks++;
            if (obs_wr[k] !== mask || obs_done[k] !== ((k == PW-1) ? mask : '0) ||
                obs_drop[k] !== (k == 0 && mask == 0) || obs_data[k] !== ed) begin
               n_fail++;
               $display("FAIL random pkt %0d word %0d: got wr=%b done=%b drop=%b data=%h, want wr=%b drop=%b data=%h",
                        p, k, obs_wr[k], obs_done[k], obs_drop[k], obs_data[k], mask, (k == 0 && mask == 0), ed);
            end
         end
         n_checks++;
         if (gap_busy !== 0) begin n_fail++; $display("FAIL random pkt %0d idle strobes: got %0d want 0", p, gap_busy); end
         if (mask != 0) exp_ram = sent[PW-1];
         $display("random pkt %0d: hdr=%h space=%b gap=%0d -> expected mask=%b", p, hdr, sp, gap, mask);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back(32'h0000_01F8, 3'b111, "b2b_ch0");
      test_sparse_ctrl();
      test_back_to_back(32'h0005_0010, 3'b111, "bad_chan");
      test_back_to_back(32'h0000_0020, 3'b111, "after_bad_chan");
      test_space_change();
      test_back_to_back(32'h0000_01FF, 3'b111, "bad_len");
      test_reset_mid_packet();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tx_chan_demux.md
# tx_chan_demux

Per-channel packet router on the txclk side, directly downstream of the USB 16→32 packer. It takes the packer's 32-bit word stream (`usbdata_final` / `WR_final`) and delineates fixed 128-word (512-byte) inband packets. It routes each packet to the channel buffer named in its header, and discards packets that are malformed, addressed to an unknown channel, or aimed at a buffer without space. It replaces a single shared TX FIFO with per-channel write strobes and packet-done pulses.

## Interface
Parameters:
- `NUM_CHAN`, default 2: number of data channels. The control channel is index `NUM_CHAN`.
- `PKT_WORDS`, default 128: words per packet, header included.

Ports:
- `txclk`  in  1  block clock. One clock; reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high reset.
- `usbdata_final`  in  32  word from packer; valid when `WR_final` is high.
- `WR_final`  in  1  word strobe. No backpressure. May be asserted on consecutive cycles.
- `have_space`  in  NUM_CHAN+1  per-buffer flag: room for one full packet.
- `ram_data`  out  32  registered copy of the accepted word.
- `WR_channel`  out  NUM_CHAN+1  one-hot write strobe aligned with `ram_data`.
- `WR_done_channel`  out  NUM_CHAN+1  one-cycle pulse on the last word of a forwarded packet.
- `pkt_dropped`  out  1  one-cycle pulse when a packet is rejected at its header.

## Operation
- Header word 0 fields:
  - `[20:16]` channel. `5'h1f` selects control (index `NUM_CHAN`).
  - `[8:0]` payload length in bytes.
- A packet is rejected when any of these holds:
  - channel ≥ `NUM_CHAN` and ≠ `5'h1f`;
  - length > 504;
  - `have_space[ch]` is low, sampled on the header cycle only.
- FSM states:
  - `IDLE`: await a header. On a `WR_final` word, latch the channel. If accepted, go to `FWD` and forward the header word. If rejected, go to `DROP` and pulse `pkt_dropped`.
  - `FWD`: forward every strobed word to `WR_channel[ch]`.
  - `DROP`: consume words silently.
  - `FWD`/`DROP` → `IDLE` on the word where the count reaches `PKT_WORDS-1`. In `FWD`, `WR_done_channel[ch]` pulses with that final word.
- Word counter: `$clog2(PKT_WORDS)` bits. Cleared to 0 in `IDLE`. Incremented only on `WR_final`; the header is word 0. It wraps to 0 at packet end and never exceeds `PKT_WORDS-1`.
- The latched channel is held for the whole packet. `have_space` changes mid-packet are ignored.
- Cycles without `WR_final` leave the state, counter and outputs idle; strobes are low.
- Reset mid-packet: force `IDLE` and zero the counter. The next strobed word is treated as a header; a partial packet is never completed.

## Timing
- Reset values: `ram_data`=0, `WR_channel`=0, `WR_done_channel`=0, `pkt_dropped`=0. State `IDLE`, counter 0.
- Latency: `WR_final` at cycle n gives `WR_channel`/`ram_data` at cycle n+1. `WR_done_channel` and `pkt_dropped` are also registered at n+1.
- Back-to-back `WR_final` is sustained at one word per cycle. The last word of one packet and the header of the next may be adjacent cycles; the header is evaluated at the first cycle back in `IDLE`.
- `ram_data` holds its value between strobes.
- Strobe outputs are never asserted together for more than one index.

## Configuration
- `TX_DEMUX_STATS_EN` defined:
  - adds output `drop_count` [15:0], a saturating count of `pkt_dropped` pulses, cleared by `reset`;
  - adds output `pkt_count` [15:0], a saturating count of forwarded packets, cleared by `reset`.
- Not defined: both ports and counters are absent. Routing behaviour is identical.

## Structure
- Shared package `tx_inband_pkg` holds:
  - header field positions (`CHAN_MSB/LSB`, `LEN_MSB/LSB`);
  - `CTRL_CHAN` = `5'h1f`;
  - `MAX_PAYLOAD` = 504;
  - the FSM state enum (`IDLE`, `FWD`, `DROP`).
- One natural sub-module: `tx_hdr_check`, combinational header decode producing channel index, accept flag and reason.
- FSM, counter and output registers stay in the top.

## Test plan
- Reset, then 128 back-to-back words, header `32'h0000_01F8` (ch 0, len 504), `have_space`=`3'b111` → `WR_channel`=`3'b001` for 128 consecutive cycles starting one cycle after the first strobe, `ram_data` equal to each input word, `WR_done_channel[0]` on word 127 only.
- Header `32'h001F_0010` (control, len 16) with `WR_final` strobed every third cycle → `WR_channel[2]` follows each strobe by 1 cycle; done pulse on the 128th strobe.
- Header `32'h0005_0010` (ch 5, invalid) → `pkt_dropped` pulse; 127 following words produce no `WR_channel`. A valid packet immediately after is forwarded intact.
- Header ch 1 with `have_space[1]`=0 → dropped. Next packet: header ch 1 with `have_space[1]`=1, and `have_space[1]` deasserted at word 10 → all 128 words forwarded.
- Header length `9'h1FF` (511) → dropped.
- `reset` asserted at word 60 of a ch 0 packet → outputs 0 the next cycle and no done pulse. The next strobed word is taken as a header and routed per its own fields.
